mult_bus_packer: RTL and testbench
==================================

# mult_bus_packer

Upstream operand packer for the multiplier array: accepts a narrow valid/ready stream of IN_LANES operand words per beat, assembles NUM_PES words into one full-width bus, and issues it to the multiplier array as a single-cycle valid pulse with a stationary flag. Sits between the operand SRAM read port and the mult array input (`i_valid` / `i_data_bus` / `i_stationary`). Provides the backpressure the array lacks, and honours a downstream stall while the distribution path reconfigures.

## Interface
- IN_DATA_TYPE, 16, operand width in bits (bf16 or int8 payload).
- NUM_PES, 64, lanes on the output bus; must be a multiple of IN_LANES.
- IN_LANES, 8, operand words per input beat; BEATS = NUM_PES/IN_LANES.
- CLK  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  packer can accept a beat this cycle.
- i_data  in  IN_LANES*IN_DATA_TYPE  beat payload; word j goes to bus lane k*IN_LANES+j for beat k.
- i_stationary  in  1  bus is a stationary (weight) load; sampled on beat 0 only.
- i_last  in  1  early end of bus (used only with MULT_PACKER_ZERO_PAD_EN).
- i_stall  in  1  downstream stall; blocks issue, not fill.
- o_valid  out  1  registered one-cycle issue pulse to the mult array.
- o_data_bus  out  NUM_PES*IN_DATA_TYPE  registered assembled bus.
- o_stationary  out  1  registered stationary flag; meaningful while o_valid=1.

## Operation
- Accept: a beat is accepted at an edge where i_valid=1 and o_ready=1.
- Beat counter beat_cnt (0..BEATS-1) selects the assembly slice; it increments on accept and wraps to 0 after the final beat.
- On beat 0, i_stationary is captured into the assembly flag. i_stationary on beats 1..BEATS-1 is ignored.
- Copy: accepting the final beat (beat_cnt=BEATS-1) moves the assembly register plus flag into o_data_bus/o_stationary and sets pend=1. The final beat's own slice is included.
- Copy is allowed only when pend=0. Therefore o_ready = !(beat_cnt==BEATS-1 && pend), a function of registers only.
- Issue: at an edge where pend=1 and i_stall=0, set o_valid<=1 and pend<=0. At every other edge, o_valid<=0.
- o_data_bus and o_stationary change only on copy, so they stay stable through the o_valid cycle.
- Non-final beats are always accepted, so fill of the next bus overlaps pend/stall.
- States are implied by {beat_cnt, pend}: FILL (pend=0), FILL_PEND (pend=1, beat_cnt<BEATS-1), BLOCKED (pend=1, beat_cnt=BEATS-1, o_ready=0).

## Timing
- Reset values: o_valid=0, o_data_bus=0, o_stationary=0, beat_cnt=0, pend=0, assembly=0. o_ready=1 in the first cycle after reset.
- Reset mid-fill discards the partial bus and any pending bus; no issue follows.
- Latency: final beat accepted at edge n, then pend=1. If i_stall=0 at edge n+1, o_valid=1 in cycle n+1..n+2.
- Stall: pend is held while i_stall=1. Issue occurs at the first edge with i_stall=0; o_valid is never asserted for more than one cycle per bus.
- Throughput: one bus per max(BEATS,2) cycles. With BEATS=1, o_ready alternates 1/0 under continuous input.
- Simultaneous events: when an issue edge (pend 1→0) coincides with a final-beat offer, the offer is not accepted (o_ready=0 that cycle). It is accepted at the next edge.

## Configuration
- MULT_PACKER_ZERO_PAD_EN defined:
  - An accepted beat with i_last=1 completes the bus immediately: copy if pend=0, else hold in BLOCKED with o_ready=0 until pend clears.
  - Lanes of beats not received are zero. The assembly register is cleared on every copy.
  - beat_cnt returns to 0.
  - i_last on beat BEATS-1 is redundant and harmless.
- MULT_PACKER_ZERO_PAD_EN undefined:
  - i_last is ignored.
  - A bus completes only after BEATS beats.
  - Assembly is not cleared; each slice is overwritten.

## Structure
- Shared package holds: BEATS derivation, BEAT_CNT_W = $clog2(BEATS) (minimum 1), and a lane-slice index function.
- Package also holds an elaboration check that NUM_PES % IN_LANES == 0.
- Single module; no sub-module is warranted. The counter and pend flag are small enough to stay inline.

## Test plan
- Basic fill (defaults, BEATS=8): 8 beats with word value = lane index and i_stationary=1 on beat 0 → o_valid one cycle, 2 edges after beat 7. o_data_bus lane i = i for i in 0..63, o_stationary=1.
- Stall: hold i_stall=1 for 5 cycles after the final beat → o_valid stays 0. One pulse arrives the cycle after the first i_stall=0 edge; data is unchanged.
- Backpressure: second bus streamed during the stall → beats 0..6 accepted, o_ready=0 at beat 7 until the issue edge. Second bus then issues intact with no lost or duplicated beats.
- Stationary sampling: i_stationary=0 on beat 0 and 1 on beats 1..7 → o_stationary=0.
- Reset mid-fill: rst=0 after beat 3, then 8 fresh beats → exactly one o_valid, carrying only the fresh data. No pulse is produced from the partial bus.
- Zero pad (macro on): i_last=1 on beat 2 → issue with lanes 0..23 = data and lanes 24..63 = 0. The next bus starts at beat_cnt=0.

Source files
------------

// File: rtl/mult_bus_packer_pkg.sv
// Shared sizing helpers for the multiplier operand packer: beat count,
// counter width, lane-slice indexing and the lane/beat divisibility check.
package mult_bus_packer_pkg;

    function automatic int calc_beats(input int num_pes, input int in_lanes);
        return num_pes / in_lanes;
    endfunction

    // Counter width with a floor of one bit so BEATS=1 still has a register.
    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lane_idx(input int beat, input int word, input int in_lanes);
        return beat * in_lanes + word;
    endfunction

    function automatic bit cfg_ok(input int num_pes, input int in_lanes);
        return (in_lanes > 0) && (num_pes >= in_lanes) && ((num_pes % in_lanes) == 0);
    endfunction

endpackage

// File: rtl/mult_bus_packer.sv
// Packs IN_LANES-wide operand beats into a NUM_PES-wide bus and issues it as a
// one-cycle pulse to the mult array. Optional feature: MULT_PACKER_ZERO_PAD_EN.
module mult_bus_packer
    import mult_bus_packer_pkg::*;
#(
    parameter int IN_DATA_TYPE = 16,
    parameter int NUM_PES      = 64,
    parameter int IN_LANES     = 8
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [IN_LANES*IN_DATA_TYPE-1:0] i_data,
    input  logic                             i_stationary,
    input  logic                             i_last,
    input  logic                             i_stall,
    output logic                             o_valid,
    output logic [NUM_PES*IN_DATA_TYPE-1:0]  o_data_bus,
    output logic                             o_stationary
);

    localparam int BEATS = calc_beats(NUM_PES, IN_LANES);
    localparam int CW    = calc_cnt_w(BEATS);
    localparam int LW    = calc_cnt_w(NUM_PES);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    generate
        if (!cfg_ok(NUM_PES, IN_LANES)) begin : g_cfg_err
            $error("mult_bus_packer: NUM_PES must be a multiple of IN_LANES");
        end
    endgenerate

    typedef logic [NUM_PES-1:0][IN_DATA_TYPE-1:0] bus_t;

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          pend_q, pend_d;
    bus_t          asm_q, asm_d;
    logic          asm_stat_q, asm_stat_d;
    logic          valid_q, valid_d;
    bus_t          bus_q, bus_d;
    logic          stat_q, stat_d;
    logic          accept, copy;

`ifdef MULT_PACKER_ZERO_PAD_EN
    // A short bus that completed while the previous one was still pending.
    logic full_q, full_d;
    logic done;
    assign o_ready = !((beat_cnt_q == LAST_BEAT) && pend_q) && !full_q;
`else
    logic unused_last;
    assign unused_last = i_last;
    assign o_ready = !((beat_cnt_q == LAST_BEAT) && pend_q);
`endif

    assign accept = i_valid && o_ready;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        asm_d      = asm_q;
        asm_stat_d = asm_stat_q;
        bus_d      = bus_q;
        stat_d     = stat_q;
        valid_d    = pend_q && !i_stall;
        pend_d     = pend_q && i_stall;
        copy       = 1'b0;
`ifdef MULT_PACKER_ZERO_PAD_EN
        full_d     = full_q;
        done       = 1'b0;
`endif
        if (accept) begin
            for (int j = 0; j < IN_LANES; j++) begin
                asm_d[LW'(lane_idx(int'(beat_cnt_q), j, IN_LANES))] =
                    i_data[j*IN_DATA_TYPE +: IN_DATA_TYPE];
            end
            if (beat_cnt_q == '0) asm_stat_d = i_stationary;
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
        end
`ifdef MULT_PACKER_ZERO_PAD_EN
        done = accept && ((beat_cnt_q == LAST_BEAT) || i_last);
        if (done) beat_cnt_d = '0;
        if ((done || full_q) && !pend_q) begin
            copy   = 1'b1;
            full_d = 1'b0;
        end else if (done) begin
            full_d = 1'b1;
        end
`else
        copy = accept && (beat_cnt_q == LAST_BEAT);
`endif
        // The final beat's slice is folded in via asm_d before the copy.
        if (copy) begin
            bus_d  = asm_d;
            stat_d = asm_stat_d;
            pend_d = 1'b1;
`ifdef MULT_PACKER_ZERO_PAD_EN
            asm_d      = '0;
            asm_stat_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            pend_q     <= 1'b0;
            asm_q      <= '0;
            asm_stat_q <= 1'b0;
            valid_q    <= 1'b0;
            bus_q      <= '0;
            stat_q     <= 1'b0;
`ifdef MULT_PACKER_ZERO_PAD_EN
            full_q     <= 1'b0;
`endif
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pend_q     <= pend_d;
            asm_q      <= asm_d;
            asm_stat_q <= asm_stat_d;
            valid_q    <= valid_d;
            bus_q      <= bus_d;
            stat_q     <= stat_d;
`ifdef MULT_PACKER_ZERO_PAD_EN
            full_q     <= full_d;
`endif
        end
    end

    assign o_valid      = valid_q;
    assign o_data_bus   = bus_q;
    assign o_stationary = stat_q;

endmodule

// File: tb/tb_mult_bus_packer.sv
// Directed bench for mult_bus_packer at default sizing (64 lanes, 8 per beat).
// Covers MULT_PACKER_ZERO_PAD_EN when the same macro is defined for the build.
module tb_mult_bus_packer;

    localparam int W  = 16;
    localparam int NP = 64;
    localparam int IL = 8;

    logic             CLK = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [IL*W-1:0]  i_data;
    logic             i_stationary;
    logic             i_last;
    logic             i_stall;
    logic             o_valid;
    logic [NP*W-1:0]  o_data_bus;
    logic             o_stationary;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;

    mult_bus_packer #(.IN_DATA_TYPE(W), .NUM_PES(NP), .IN_LANES(IL)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_stationary (i_stationary),
        .i_last       (i_last),
        .i_stall      (i_stall),
        .o_valid      (o_valid),
        .o_data_bus   (o_data_bus),
        .o_stationary (o_stationary)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (o_valid === 1'b1) vcnt++;

    function automatic logic [IL*W-1:0] mk_beat(input int base);
        logic [IL*W-1:0] d;
        d = '0;
        for (int j = 0; j < IL; j++) d[j*W +: W] = W'(base + j);
        return d;
    endfunction

    function automatic logic [NP*W-1:0] exp_bus(input int base, input int nlanes);
        logic [NP*W-1:0] b;
        b = '0;
        for (int i = 0; i < nlanes; i++) b[i*W +: W] = W'(base + i);
        return b;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [NP*W-1:0] exp);
        int bad;
        bad = -1;
        for (int i = NP - 1; i >= 0; i--)
            if (o_data_bus[i*W +: W] !== exp[i*W +: W]) bad = i;
        checks++;
        assert (o_data_bus === exp) else begin
            failures++;
            $error("FAIL %s lane=%0d obs=%0h exp=%0h", tag, bad,
                   o_data_bus[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one beat, waiting (bounded) for o_ready, then consume one edge.
    task automatic send(input logic [IL*W-1:0] d, input logic st, input logic lst);
        int n;
        i_valid = 1'b1; i_data = d; i_stationary = st; i_last = lst;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", int'(o_ready), 1);
        tick();
        i_valid = 1'b0; i_last = 1'b0; i_stationary = 1'b0;
    endtask

    task automatic send_bus(input int base, input logic st0, input logic st_rest,
                            input int nb, input int last_at);
        for (int k = 0; k < nb; k++)
            send(mk_beat(base + k*IL), (k == 0) ? st0 : st_rest, k == last_at);
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_data = '0; i_stationary = 1'b0;
        i_last = 1'b0; i_stall = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_stat", int'(o_stationary), 0);
        chk_bus("rst_bus", '0);

        // Basic fill: issue lands two edges after the final beat.
        send_bus(0, 1'b1, 1'b0, 8, -1);
        chk("basic_lat0", int'(o_valid), 0);
        tick();
        chk("basic_valid", int'(o_valid), 1);
        chk_bus("basic_bus", exp_bus(0, 64));
        chk("basic_stat", int'(o_stationary), 1);
        tick();
        chk("basic_pulse_end", int'(o_valid), 0);
        chk("basic_vcnt", vcnt, 1);

        // Stall with a second bus streamed behind it.
        i_stall = 1'b1;
        send_bus(100, 1'b1, 1'b0, 8, -1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_hold", int'(o_valid), 0);
            tick();
        end
        send_bus(200, 1'b0, 1'b1, 7, -1);
        chk("bp_no_valid", int'(o_valid), 0);
        chk_bus("bp_bus_stable", exp_bus(100, 64));
        i_valid = 1'b1; i_data = mk_beat(200 + 7*IL); i_stationary = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_blocked", int'(o_ready), 0);
            tick();
        end
        chk("bp_stall_valid", int'(o_valid), 0);
        i_stall = 1'b0;
        tick();
        chk("stall_issue", int'(o_valid), 1);
        chk_bus("stall_bus", exp_bus(100, 64));
        chk("stall_stat", int'(o_stationary), 1);
        chk("bp_ready_after_issue", int'(o_ready), 1);
        tick();
        i_valid = 1'b0; i_stationary = 1'b0;
        chk("bp_gap", int'(o_valid), 0);
        chk_bus("bp_copy", exp_bus(200, 64));
        tick();
        chk("bp_issue", int'(o_valid), 1);
        chk_bus("bp_bus", exp_bus(200, 64));
        chk("stat_sample", int'(o_stationary), 0);
        tick();
        chk("bp_vcnt", vcnt, 3);

        // Reset mid-fill discards the partial bus.
        send_bus(300, 1'b1, 1'b1, 4, -1);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_ready", int'(o_ready), 1);
        chk_bus("midrst_bus", '0);
        rst = 1'b1;
        send_bus(400, 1'b1, 1'b0, 8, -1);
        repeat (4) tick();
        chk("midrst_vcnt", vcnt, 4);
        chk_bus("midrst_fresh_bus", exp_bus(400, 64));
        chk("midrst_stat", int'(o_stationary), 1);

`ifdef MULT_PACKER_ZERO_PAD_EN
        send_bus(500, 1'b1, 1'b0, 3, 2);
        tick();
        chk("zp_valid", int'(o_valid), 1);
        chk_bus("zp_bus", exp_bus(500, 24));
        chk("zp_stat", int'(o_stationary), 1);
        send_bus(600, 1'b0, 1'b1, 8, -1);
        tick();
        chk("zp_next_valid", int'(o_valid), 1);
        chk_bus("zp_next_bus", exp_bus(600, 64));
        tick();
        chk("zp_vcnt", vcnt, 6);
`else
        // i_last is inert: the bus still needs all eight beats.
        send_bus(500, 1'b1, 1'b0, 3, 2);
        tick();
        chk("nolast_no_issue", int'(o_valid), 0);
        chk("nolast_vcnt", vcnt, 4);
        send_bus(524, 1'b0, 1'b0, 5, -1);
        tick();
        chk("nolast_valid", int'(o_valid), 1);
        chk_bus("nolast_bus", exp_bus(500, 64));
        chk("nolast_stat", int'(o_stationary), 1);
        tick();
        chk("nolast_vcnt_end", vcnt, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
